conv3x3_filter: RTL and testbench



---
 rtl/conv3x3_pkg.sv | 26 ++
 rtl/conv3x3_linebuf.sv | 31 +++
 rtl/conv3x3_filter.sv | 227 ++++++++++++++++++++++
 tb/tb_conv3x3_filter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// Shared types, default kernel and width helpers for the conv3x3 filter.
package conv3x3_pkg;

    typedef enum logic { BM_ZERO = 1'b0, BM_REPL = 1'b1 } bmode_e;

    typedef enum logic [1:0] { IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2 } state_e;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    localparam int unsigned NTAPS = 9;

    // Smoothing kernel with unit gain at 7 fractional bits.
    localparam int DEF_KERNEL [NTAPS] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

    function automatic int unsigned prod_w(input int unsigned dw, input int unsigned cw);
        return dw + cw + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned dw, input int unsigned cw);
        return dw + cw + 5;
    endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// Two-line pixel history; combinational read and write at the same column address.
module conv3x3_linebuf
    import conv3x3_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned AW     = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] row0_c,
    output logic [DATA_W-1:0] row1_c
);

    // Contents need no reset: stale lines are masked by the boundary logic.
    logic [DATA_W-1:0] row0 [IMG_W];
    logic [DATA_W-1:0] row1 [IMG_W];

    assign row0_c = row0[addr];
    assign row1_c = row1[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            row1[addr] <= row0[addr];
            row0[addr] <= din;
        end
    end

endmodule

// File: rtl/conv3x3_filter.sv
// Streaming programmable 3x3 convolution with zero/replicate borders and self-flush.
// Define CONV3X3_ABS_OUT_EN to output |result| instead of clamping negatives to 0.
module conv3x3_filter
    import conv3x3_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COEF_W    = 8,
    parameter int unsigned IMG_W     = 256,
    parameter int unsigned IMG_H     = 256,
    parameter int unsigned FRAC_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_eof,
    output logic              o_err,
    input  logic              bmode,
    input  logic              k_we,
    input  logic [3:0]        k_idx,
    input  logic [COEF_W-1:0] k_data
);

    localparam int unsigned PW   = prod_w(DATA_W, COEF_W);
    localparam int unsigned SW   = sum_w(DATA_W, COEF_W);
    localparam int unsigned XW   = $clog2(IMG_W);
    localparam int unsigned YW   = $clog2(IMG_H);
    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned PCW  = $clog2(NPIX + IMG_W + 2);
    localparam int unsigned FCW  = $clog2(IMG_W + 1);
    localparam int unsigned RND  = (FRAC_BITS > 0) ? (1 << (FRAC_BITS - 1)) : 0;
    localparam int unsigned PMAX = (1 << DATA_W) - 1;

    state_e                   state, state_n;
    logic                     push, start, err;
    logic [DATA_W-1:0]        pix;
    logic [XW-1:0]            addr;
    logic [DATA_W-1:0]        row0_c, row1_c;

    logic [PCW-1:0]           pcnt;
    logic [XW-1:0]            px, ccx, wcx;
    logic [YW-1:0]            ccy, wcy;
    logic [FCW-1:0]           fcnt;
    bmode_e                   bm;
    logic signed [COEF_W-1:0] kshadow [NTAPS];
    logic signed [COEF_W-1:0] kactive [NTAPS];
    logic [DATA_W-1:0]        win [3][3];
    logic                     wv, wlast;

    logic [DATA_W-1:0]        tap [NTAPS];
    logic signed [PW-1:0]     prod_q [NTAPS];
    logic signed [SW-1:0]     sum_c, sum_q, rnd_c, mag_c;
    logic [DATA_W-1:0]        res_c;
    tag_t                     s1, s2;

    // Frame FSM: decides whether this cycle is a push and whether it starts a frame.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        start   = 1'b0;
        err     = 1'b0;
        pix     = i_data;
        case (state)
            IDLE: begin
                if (i_valid && i_ready && i_sof) begin
                    push    = 1'b1;
                    start   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (i_valid && i_ready) begin
                    push = 1'b1;
                    if (i_sof) begin
                        start = 1'b1;
                        err   = 1'b1;
                    end else if (pcnt == PCW'(NPIX - 1)) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                push = 1'b1;
                pix  = '0;
                if (fcnt == FCW'(IMG_W)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        addr = start ? '0 : px;
    end

    conv3x3_linebuf #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(XW)) u_linebuf (
        .clk    (clk),
        .we     (push),
        .addr   (addr),
        .din    (pix),
        .row0_c (row0_c),
        .row1_c (row1_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            i_ready <= 1'b1;
            o_err   <= 1'b0;
            pcnt    <= '0;
            px      <= '0;
            ccx     <= '0;
            ccy     <= '0;
            wcx     <= '0;
            wcy     <= '0;
            fcnt    <= '0;
            bm      <= BM_ZERO;
            wv      <= 1'b0;
            wlast   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                kshadow[i] <= COEF_W'(DEF_KERNEL[i]);
                kactive[i] <= COEF_W'(DEF_KERNEL[i]);
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win[r][c] <= '0;
        end else begin
            state   <= state_n;
            i_ready <= (state_n != FLUSH);
            o_err   <= err;
            if (k_we && k_idx < 4'd9) kshadow[k_idx] <= k_data;
            if (start) begin
                kactive <= kshadow;
                bm      <= bmode_e'(bmode);
            end
            wv <= 1'b0;
            if (push) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= row1_c;
                win[1][2] <= row0_c;
                win[2][2] <= pix;
                px <= (addr == XW'(IMG_W - 1)) ? '0 : addr + 1'b1;
                if (start) begin
                    pcnt <= PCW'(1);
                    ccx  <= '0;
                    ccy  <= '0;
                    fcnt <= '0;
                end else begin
                    pcnt <= pcnt + 1'b1;
                    if (state == FLUSH) fcnt <= fcnt + 1'b1;
                    // The window has a real centre once a line plus one pixel is buffered.
                    if (pcnt >= PCW'(IMG_W + 1)) begin
                        wv    <= 1'b1;
                        wcx   <= ccx;
                        wcy   <= ccy;
                        wlast <= (ccx == XW'(IMG_W - 1)) && (ccy == YW'(IMG_H - 1));
                        if (ccx == XW'(IMG_W - 1)) begin
                            ccx <= '0;
                            ccy <= ccy + 1'b1;
                        end else begin
                            ccx <= ccx + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Border taps: zero them, or fold them onto the centre row/column.
    always_comb begin
        logic [1:0] rs, cs;
        logic       zero;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                rs   = 2'(r);
                cs   = 2'(c);
                zero = 1'b0;
                if ((r == 0 && wcy == '0) || (r == 2 && wcy == YW'(IMG_H - 1))) begin
                    if (bm == BM_REPL) rs = 2'd1;
                    else zero = 1'b1;
                end
                if ((c == 0 && wcx == '0) || (c == 2 && wcx == XW'(IMG_W - 1))) begin
                    if (bm == BM_REPL) cs = 2'd1;
                    else zero = 1'b1;
                end
                tap[r*3+c] = zero ? '0 : win[rs][cs];
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NTAPS; i++) sum_c = sum_c + SW'(prod_q[i]);
        rnd_c = (sum_q + $signed(SW'(RND))) >>> FRAC_BITS;
`ifdef CONV3X3_ABS_OUT_EN
        mag_c = rnd_c[SW-1] ? -rnd_c : rnd_c;
`else
        mag_c = rnd_c[SW-1] ? '0 : rnd_c;
`endif
        res_c = (mag_c > $signed(SW'(PMAX))) ? DATA_W'(PMAX) : DATA_W'(mag_c);
    end

    // Multiply, sum, round; a restart kills every slot still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) prod_q[i] <= '0;
            sum_q   <= '0;
            s1      <= '0;
            s2      <= '0;
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
            o_data  <= '0;
        end else begin
            for (int i = 0; i < NTAPS; i++)
                prod_q[i] <= PW'($signed({1'b0, tap[i]})) * PW'(kactive[i]);
            sum_q   <= sum_c;
            s1      <= err ? '0 : tag_t'({wv, wlast});
            s2      <= err ? '0 : s1;
            o_valid <= s2.vld & ~err;
            o_eof   <= s2.vld & s2.last & ~err;
            o_data  <= res_c;
        end
    end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Scoreboard bench for conv3x3_filter on a 4x3 image; expected pixels come from a direct 2D model.
module tb_conv3x3_filter;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int N    = W * H;
    localparam int FRAC = 7;

    typedef struct {
        int data;
        bit eof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic       i_sof = 1'b0;
    logic [7:0] i_data = '0;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_eof;
    logic       o_err;
    logic       bmode = 1'b0;
    logic       k_we = 1'b0;
    logic [3:0] k_idx = '0;
    logic [7:0] k_data = '0;

    int   total = 0;
    int   bad = 0;
    int   vcount = 0;
    int   img [N];
    int   tb_shadow [9];
    int   tb_active [9];
    int   kdef [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
    exp_t sb [$];
    bit   ready_s, eof_s;

    conv3x3_filter #(.DATA_W(8), .COEF_W(8), .IMG_W(W), .IMG_H(H), .FRAC_BITS(FRAC)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_sof(i_sof),
        .i_data(i_data), .o_valid(o_valid), .o_data(o_data), .o_eof(o_eof), .o_err(o_err),
        .bmode(bmode), .k_we(k_we), .k_idx(k_idx), .k_data(k_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int model_px(input int x, input int y, input int bm);
        int acc, r, nx, ny;
        bit outside;
        acc = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                outside = (nx < 0 || nx >= W || ny < 0 || ny >= H);
                if (!outside || bm != 0) begin
                    if (nx < 0) nx = 0;
                    if (nx >= W) nx = W - 1;
                    if (ny < 0) ny = 0;
                    if (ny >= H) ny = H - 1;
                    acc += tb_active[(dy+1)*3 + dx + 1] * img[ny*W + nx];
                end
            end
        end
        r = (acc + (1 << (FRAC - 1))) >>> FRAC;
`ifdef CONV3X3_ABS_OUT_EN
        if (r < 0) r = -r;
`else
        if (r < 0) r = 0;
`endif
        if (r > 255) r = 255;
        return r;
    endfunction

    // One clock: sample outputs at the falling edge, pop/compare scoreboard, land #1 after rise.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        ready_s = i_ready;
        eof_s   = o_valid && o_eof;
        if (!rst && o_valid) begin
            vcount++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got data=%0d eof=%0d, required no output", o_data, o_eof);
            end else begin
                e = sb.pop_front();
                total++;
                if (int'(o_data) !== e.data) begin
                    bad++;
                    $display("FAIL out_data got=%0d required=%0d", o_data, e.data);
                end
                total++;
                if (o_eof !== e.eof) begin
                    bad++;
                    $display("FAIL out_eof got=%0d required=%0d", o_eof, e.eof);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int bm);
        exp_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.data = model_px(x, y, bm);
                e.eof  = (x == W - 1) && (y == H - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive_px(input int val, input bit sof);
        bit acc;
        int n;
        i_valid = 1'b1;
        i_data  = 8'(val);
        i_sof   = sof;
        n = 0;
        do begin
            acc = i_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL px_accept got i_ready=0 for 100 cycles, required 1");
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic write_coef(input int idx, input int val);
        k_we   = 1'b1;
        k_idx  = 4'(idx);
        k_data = 8'(val);
        tick();
        k_we = 1'b0;
        if (idx < 9) tb_shadow[idx] = val;
    endtask

    task automatic set_kernel(input int kv [9]);
        for (int j = 0; j < 9; j++) write_coef(j, kv[j]);
    endtask

    task automatic begin_frame(input int bm);
        for (int n = 0; n < 100 && !i_ready; n++) tick();
        if (!i_ready) begin
            total++;
            bad++;
            $display("FAIL frame_ready got i_ready=0, required 1");
        end
        bmode = bm[0];
        tb_active = tb_shadow;
        push_expect(bm);
    endtask

    task automatic send_frame(input int bm, input bit gaps);
        begin_frame(bm);
        for (int i = 0; i < N; i++) begin
            drive_px(img[i], i == 0);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d, required 0", sb.size());
        end
        repeat (3) tick();
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic fill_ramp(input int seed);
        for (int i = 0; i < N; i++) img[i] = (i * 37 + seed) % 256;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tb_shadow = kdef;
        tb_active = kdef;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if ({o_valid, o_eof, o_err, i_ready} !== 4'b0001 || o_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_state got v=%0d eof=%0d err=%0d rdy=%0d data=%0d, required 0 0 0 1 0",
                     o_valid, o_eof, o_err, i_ready, o_data);
        end
    endtask

    task automatic test_zero_pad();
        int vb;
        fill_const(100);
        vb = vcount;
        begin_frame(0);
        for (int i = 0; i < N; i++) begin
            drive_px(img[i], i == 0);
            if (i == 0) begin
                total++;
                if (o_err !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_sof_err got=%0d required=0", o_err);
                end
            end
        end
        wait_drain();
        total++;
        if (vcount - vb !== N) begin
            bad++;
            $display("FAIL zero_pad_count got=%0d required=%0d", vcount - vb, N);
        end
    endtask

    task automatic test_replicate();
        fill_const(100);
        send_frame(1, 1'b0);
        wait_drain();
        fill_ramp(11);
        send_frame(1, 1'b0);
        wait_drain();
    endtask

    task automatic test_flush_gaps();
        int lowcnt, eof_at;
        fill_ramp(5);
        begin_frame(0);
        for (int i = 0; i < N; i++) begin
            drive_px(img[i], i == 0);
            if (i != N - 1) repeat ($urandom_range(0, 2)) tick();
        end
        lowcnt = 0;
        eof_at = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!ready_s) lowcnt++;
            if (eof_s && eof_at < 0) eof_at = n;
        end
        total++;
        if (lowcnt !== W + 1) begin
            bad++;
            $display("FAIL flush_ready_low got=%0d required=%0d", lowcnt, W + 1);
        end
        total++;
        if (eof_at !== W + 4) begin
            bad++;
            $display("FAIL eof_latency got=%0d required=%0d", eof_at, W + 4);
        end
        wait_drain();
        fill_ramp(200);
        send_frame(1, 1'b1);
        wait_drain();
    endtask

    task automatic test_saturation_abs();
        int k127 [9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        int kneg [9] = '{0, 0, 0, 0, -128, 0, 0, 0, 0};
        set_kernel(k127);
        fill_const(255);
        send_frame(0, 1'b0);
        wait_drain();
        set_kernel(kneg);
        fill_const(10);
        send_frame(0, 1'b0);
        wait_drain();
    endtask

    task automatic test_kernel_shadow();
        set_kernel(kdef);
        fill_const(100);
        begin_frame(0);
        for (int i = 0; i < N; i++) begin
            drive_px(img[i], i == 0);
            if (i == 5) begin
                for (int j = 0; j < 9; j++) write_coef(j, (j == 4) ? 64 : 0);
                write_coef(9, 127);
            end
        end
        wait_drain();
        send_frame(0, 1'b0);
        wait_drain();
    endtask

    task automatic test_restart();
        set_kernel(kdef);
        fill_ramp(90);
        begin_frame(0);
        for (int i = 0; i < 5; i++) drive_px(img[i], i == 0);
        sb.delete();
        tb_active = tb_shadow;
        push_expect(0);
        drive_px(img[0], 1'b1);
        total++;
        if (o_err !== 1'b1) begin
            bad++;
            $display("FAIL restart_err_pulse got=%0d required=1", o_err);
        end
        tick();
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL restart_err_width got=%0d required=0", o_err);
        end
        for (int i = 1; i < N; i++) drive_px(img[i], 1'b0);
        wait_drain();
    endtask

    task automatic test_reset_mid_flush();
        int vb;
        fill_ramp(3);
        send_frame(0, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        tb_shadow = kdef;
        tb_active = kdef;
        total++;
        if (i_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_flush_ready got=%0d required=1", i_ready);
        end
        vb = vcount;
        repeat (20) tick();
        for (int i = 0; i < 3; i++) drive_px(50, 1'b0);
        repeat (15) tick();
        total++;
        if (vcount !== vb) begin
            bad++;
            $display("FAIL rst_flush_silent got=%0d outputs required=0", vcount - vb);
        end
        send_frame(0, 1'b0);
        wait_drain();
        total++;
        if (vcount - vb !== N) begin
            bad++;
            $display("FAIL post_rst_count got=%0d required=%0d", vcount - vb, N);
        end
    endtask

    initial begin
        test_reset();
        test_zero_pad();
        test_replicate();
        test_flush_gaps();
        test_saturation_abs();
        test_kernel_shadow();
        test_restart();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
